// File: rtl/chunk_copy_pkg.sv
// Shared types and the elaboration-time parameter check for the chunked word copier.
package chunk_copy_pkg;

  typedef enum logic [1:0] {IDLE, COPY, DONE} chunk_copy_state_t;

  // The counter must reach WIDTH-CHUNK without wrapping, and chunks must tile the word exactly.
  function automatic bit params_ok(int width, int chunk, int idxw);
    bit ok;
    ok = (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0) && (idxw >= 1);
    if (ok && idxw < 31) ok = ((1 << idxw) > (width - chunk));
    return ok;
  endfunction

endpackage

// File: rtl/chunk_copy_seq_if.sv
// Handshake and data bundle between a word source/consumer and chunk_copy_seq.
interface chunk_copy_seq_if #(
  parameter int WIDTH = 128,
  parameter int IDXW  = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic [IDXW-1:0]  idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, idx
  );
endinterface

// File: rtl/chunk_idx_ctr.sv
// Chunk base index counter: clears, steps by CHUNK, and flags the last chunk of the word.
module chunk_idx_ctr #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 8,
  parameter int IDXW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            step_i,
  output logic [IDXW-1:0] idx_o,
  output logic            last_o
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - CHUNK);
  localparam logic [IDXW-1:0] STEP     = IDXW'(CHUNK);

  logic [IDXW-1:0] idx_q, idx_d;

  // Equality against the last base index ends the sweep, so the counter never wraps.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (step_i) begin
      idx_d = last_o ? '0 : idx_q + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/chunk_copy_seq.sv
// Accepts a WIDTH-bit word, copies it CHUNK bits per cycle into the output register, then offers it.
module chunk_copy_seq
  import chunk_copy_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CHUNK = 8,
  parameter int IDXW  = 8
) (
  input logic             clk,
  input logic             rst,
  chunk_copy_seq_if.slave bus
);

  if (!params_ok(WIDTH, CHUNK, IDXW)) begin : g_param_fatal
    $fatal(1, "chunk_copy_seq: WIDTH must be a multiple of CHUNK and 2**IDXW must exceed WIDTH-CHUNK");
  end

  localparam logic [WIDTH-1:0] CHUNK_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

  chunk_copy_state_t state_q, state_d;
  logic [WIDTH-1:0]  src_q, src_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [WIDTH-1:0]  copy_mask;
  logic [IDXW-1:0]   idx;
  logic              idx_clr, idx_step, idx_last;

  chunk_idx_ctr #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK),
    .IDXW  (IDXW)
  ) u_idx_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear_i (idx_clr),
    .step_i  (idx_step),
    .idx_o   (idx),
    .last_o  (idx_last)
  );

  // The mask selects out_data[idx +: CHUNK]; only that slice is refreshed from src each copy cycle.
  assign copy_mask = CHUNK_MASK << idx;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    out_d    = out_q;
    idx_clr  = 1'b0;
    idx_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          src_d   = bus.in_data;
          out_d   = '0;
          idx_clr = 1'b1;
          state_d = COPY;
        end
      end
      COPY: begin
        out_d    = (out_q & ~copy_mask) | (src_q & copy_mask);
        idx_step = 1'b1;
        if (idx_last) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = out_q;
  assign bus.idx       = idx;

endmodule
